// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// Request bundle, FSM states and word geometry.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables.
// Read data is registered on the same edge as the access.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the core's data-memory port.
// One request in flight, fixed latency, error on bad address.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [32:0] END_ADDR =
        {1'b0, BASE_ADDR} + 33'(WORD_BYTES * DEPTH_WORDS);

    dmem_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dmem_req_t     req_q, cur;
    logic          err_q, cur_err, commit;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   ram_rdata;

    // With LATENCY==1 the commit happens on the accept edge, so the
    // live request must feed the RAM while still in IDLE.
    always_comb begin
        cur = req_q;
        if (state_q == IDLE) begin
            cur = '{write: req_write, addr: req_addr,
                    wdata: req_wdata, wstrb: req_wstrb};
        end
    end

    assign cur_err = (cur.addr[1:0] != 2'b00)
                  || (cur.addr < BASE_ADDR)
                  || ({1'b0, cur.addr} >= END_ADDR);

    // Base is aligned to the array size, so the low bits index directly.
    assign idx = cur.addr[AW+1:2];
    assign be  = (commit && cur.write && !cur_err) ? cur.wstrb : 4'b0000;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_valid) req_q <= cur;
            if (commit) err_q <= cur_err;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   (commit),
        .be   (be),
        .addr (idx),
        .wdata(cur.wdata),
        .rdata(ram_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !req_q.write && !err_q) ? ram_rdata : 32'h0;

endmodule
